control_sequencer: RTL and testbench

Hardwired control unit for the bus-based datapath. It is the driving end of the datapath control interface. It steps the fetch/execute T-states and emits the one-hot register-transfer strobes the datapath consumes: PCout, MARin, Read, MDRin, MDRout, IRin, Yin, ZLowIn, Zlowout, and the rest of that set. It decodes IR[31:27] and drives the ALU opcode. Register selection is done through Gra/Grb/Grc with Rin/Rout, which the external select-and-encode logic consumes.

---
 rtl/control_sequencer_pkg.sv | 51 +++++
 rtl/control_sequencer_if.sv | 30 +++
 rtl/ctrl_opclass_decode.sv | 24 ++
 rtl/control_sequencer.sv | 172 +++++++++++++++++
 tb/tb_control_sequencer.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared control-unit definitions: opcode values, FSM state encoding and opcode classes.
package cpu_ctrl_pkg;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_ROR  = 5'b00111;
   localparam logic [4:0] OP_ROL  = 5'b01000;
   localparam logic [4:0] OP_SHR  = 5'b01001;
   localparam logic [4:0] OP_SHRA = 5'b01010;
   localparam logic [4:0] OP_SHL  = 5'b01011;
   localparam logic [4:0] OP_DIV  = 5'b01111;
   localparam logic [4:0] OP_MUL  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   localparam logic [3:0] ST_IDLE = 4'd0;
   localparam logic [3:0] ST_T0   = 4'd1;
   localparam logic [3:0] ST_T1   = 4'd2;
   localparam logic [3:0] ST_T2   = 4'd3;
   localparam logic [3:0] ST_T3   = 4'd4;
   localparam logic [3:0] ST_T4   = 4'd5;
   localparam logic [3:0] ST_T5   = 4'd6;
   localparam logic [3:0] ST_T6   = 4'd7;
   localparam logic [3:0] ST_HALT = 4'd8;

   typedef enum logic [3:0] {
      S_IDLE = ST_IDLE,
      S_T0   = ST_T0,
      S_T1   = ST_T1,
      S_T2   = ST_T2,
      S_T3   = ST_T3,
      S_T4   = ST_T4,
      S_T5   = ST_T5,
      S_T6   = ST_T6,
      S_HALT = ST_HALT
   } state_t;

   typedef enum logic [2:0] {
      CLS_RTYPE,
      CLS_UNARY,
      CLS_MULDIV,
      CLS_NOP,
      CLS_HALT,
      CLS_ILLEGAL
   } op_class_t;

endpackage

// File: rtl/control_sequencer_if.sv
// Datapath control interface: register-transfer strobes and ALU opcode out, IR contents back.
interface control_sequencer_if #(
   parameter int OPC_W = 5,
   parameter int IR_W  = 32
);
   logic             PCout, Zhighout, Zlowout, MDRout;
   logic             MARin, PCin, MDRin, IRin, Yin, IncPC, Read;
   logic             HIin, LOin, ZHighIn, ZLowIn;
   logic             Gra, Grb, Grc, Rin, Rout;
   logic [OPC_W-1:0] alu_op;
   logic [IR_W-1:0]  ir;

   modport master (
      output PCout, Zhighout, Zlowout, MDRout,
      output MARin, PCin, MDRin, IRin, Yin, IncPC, Read,
      output HIin, LOin, ZHighIn, ZLowIn,
      output Gra, Grb, Grc, Rin, Rout,
      output alu_op,
      input  ir
   );

   modport slave (
      input  PCout, Zhighout, Zlowout, MDRout,
      input  MARin, PCin, MDRin, IRin, Yin, IncPC, Read,
      input  HIin, LOin, ZHighIn, ZLowIn,
      input  Gra, Grb, Grc, Rin, Rout,
      input  alu_op,
      output ir
   );
endinterface

// File: rtl/ctrl_opclass_decode.sv
// Combinational opcode classifier; reused by other control blocks (branch, load/store).
module ctrl_opclass_decode
   import cpu_ctrl_pkg::*;
#(
   parameter int OPC_W = 5
) (
   input  logic [OPC_W-1:0] opcode,
   output op_class_t        op_class
);

   always_comb begin
      op_class = CLS_ILLEGAL;
      case (opcode)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
         OP_ROL, OP_SHR, OP_SHRA, OP_SHL: op_class = CLS_RTYPE;
         OP_NEG, OP_NOT:                  op_class = CLS_UNARY;
         OP_MUL, OP_DIV:                  op_class = CLS_MULDIV;
         OP_NOP:                          op_class = CLS_NOP;
         OP_HALT:                         op_class = CLS_HALT;
         default:                         op_class = CLS_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer driving the datapath strobes.
// Optional SEQ_INSTR_COUNT_EN adds the retired-instruction counter output.
//
// state | meaning
// IDLE  | waiting for run
// T0    | PC -> MAR, increment PC
// T1    | memory read into MDR, held until mem_ready
// T2    | MDR -> IR
// T3    | decode; first operand -> Y, or retire nop/illegal, or enter HALT
// T4    | ALU operate, result into Z
// T5    | Zlow -> Ra (last step) or Zlow -> LO (mul/div)
// T6    | Zhigh -> HI (mul/div last step)
// HALT  | halted, left only by clear
module control_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int OPC_W = 5,
   parameter int IR_W  = 32
) (
   input  logic        clock,
   input  logic        clear,
   input  logic        run,
   input  logic        mem_ready,
   control_sequencer_if.master bus,
   output logic        halted,
`ifdef SEQ_INSTR_COUNT_EN
   output logic [31:0] retired,
`endif
   output logic        illegal
);

   state_t           state, state_nxt, resume_st;
   op_class_t        op_class;
   logic [OPC_W-1:0] opcode;
   logic             retire_evt;
   logic             ir_unused;

   assign opcode    = bus.ir[IR_W-1 -: OPC_W];
   assign ir_unused = ^bus.ir[IR_W-OPC_W-1:0];
   assign resume_st = run ? S_T0 : S_IDLE;

   ctrl_opclass_decode #(.OPC_W(OPC_W)) u_decode (
      .opcode   (opcode),
      .op_class (op_class)
   );

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      bus.PCout    = 1'b0;
      bus.Zhighout = 1'b0;
      bus.Zlowout  = 1'b0;
      bus.MDRout   = 1'b0;
      bus.MARin    = 1'b0;
      bus.PCin     = 1'b0;
      bus.MDRin    = 1'b0;
      bus.IRin     = 1'b0;
      bus.Yin      = 1'b0;
      bus.IncPC    = 1'b0;
      bus.Read     = 1'b0;
      bus.HIin     = 1'b0;
      bus.LOin     = 1'b0;
      bus.ZHighIn  = 1'b0;
      bus.ZLowIn   = 1'b0;
      bus.Gra      = 1'b0;
      bus.Grb      = 1'b0;
      bus.Grc      = 1'b0;
      bus.Rin      = 1'b0;
      bus.Rout     = 1'b0;
      bus.alu_op   = '0;
      halted       = 1'b0;
      illegal      = 1'b0;
      retire_evt   = 1'b0;
      case (state)
         S_IDLE: if (run) state_nxt = S_T0;
         S_T0: begin
            bus.PCout = 1'b1;
            bus.MARin = 1'b1;
            bus.IncPC = 1'b1;
            state_nxt = S_T1;
         end
         S_T1: begin
            bus.Read  = 1'b1;
            bus.MDRin = 1'b1;
            if (mem_ready) state_nxt = S_T2;
         end
         S_T2: begin
            bus.MDRout = 1'b1;
            bus.IRin   = 1'b1;
            state_nxt  = S_T3;
         end
         S_T3: begin
            case (op_class)
               CLS_RTYPE, CLS_UNARY: begin
                  bus.Grb   = 1'b1;
                  bus.Rout  = 1'b1;
                  bus.Yin   = 1'b1;
                  state_nxt = S_T4;
               end
               CLS_MULDIV: begin
                  bus.Gra   = 1'b1;
                  bus.Rout  = 1'b1;
                  bus.Yin   = 1'b1;
                  state_nxt = S_T4;
               end
               CLS_NOP: begin
                  retire_evt = 1'b1;
                  state_nxt  = resume_st;
               end
               CLS_HALT: begin
                  retire_evt = 1'b1;
                  state_nxt  = S_HALT;
               end
               default: begin
                  illegal    = 1'b1;
                  retire_evt = 1'b1;
                  state_nxt  = resume_st;
               end
            endcase
         end
         S_T4: begin
            bus.alu_op  = opcode;
            bus.ZHighIn = 1'b1;
            bus.ZLowIn  = 1'b1;
            // unary ops take their only operand from Y, so the bus stays undriven
            if (op_class == CLS_RTYPE) begin
               bus.Grc  = 1'b1;
               bus.Rout = 1'b1;
            end else if (op_class == CLS_MULDIV) begin
               bus.Grb  = 1'b1;
               bus.Rout = 1'b1;
            end
            state_nxt = S_T5;
         end
         S_T5: begin
            bus.Zlowout = 1'b1;
            if (op_class == CLS_MULDIV) begin
               bus.LOin  = 1'b1;
               state_nxt = S_T6;
            end else begin
               bus.Gra    = 1'b1;
               bus.Rin    = 1'b1;
               retire_evt = 1'b1;
               state_nxt  = resume_st;
            end
         end
         S_T6: begin
            bus.Zhighout = 1'b1;
            bus.HIin     = 1'b1;
            retire_evt   = 1'b1;
            state_nxt    = resume_st;
         end
         S_HALT: halted = 1'b1;
         default: state_nxt = S_IDLE;
      endcase
   end

`ifdef SEQ_INSTR_COUNT_EN
   always_ff @(posedge clock or negedge clear) begin
      if (!clear)          retired <= '0;
      else if (retire_evt) retired <= retired + 32'd1;
   end
`else
   logic retire_unused;
   assign retire_unused = retire_evt;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: driver queues expected per-cycle outputs, monitor compares.
module tb_control_sequencer;
   import cpu_ctrl_pkg::*;

   logic clock = 1'b0;
   logic clear = 1'b0;
   logic run = 1'b0;
   logic mem_ready = 1'b0;
   logic halted, illegal;
`ifdef SEQ_INSTR_COUNT_EN
   logic [31:0] retired;
`endif

   control_sequencer_if bus ();

   control_sequencer dut (
      .clock     (clock),
      .clear     (clear),
      .run       (run),
      .mem_ready (mem_ready),
      .bus       (bus.master),
      .halted    (halted),
`ifdef SEQ_INSTR_COUNT_EN
      .retired   (retired),
`endif
      .illegal   (illegal)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [19:0] str;
      logic [4:0]  alu;
      logic        hlt;
      logic        ill;
   } obs_t;

   localparam logic [19:0] M_PCOUT    = 20'd1 << 0;
   localparam logic [19:0] M_ZHIGHOUT = 20'd1 << 1;
   localparam logic [19:0] M_ZLOWOUT  = 20'd1 << 2;
   localparam logic [19:0] M_MDROUT   = 20'd1 << 3;
   localparam logic [19:0] M_MARIN    = 20'd1 << 4;
   localparam logic [19:0] M_PCIN     = 20'd1 << 5;
   localparam logic [19:0] M_MDRIN    = 20'd1 << 6;
   localparam logic [19:0] M_IRIN     = 20'd1 << 7;
   localparam logic [19:0] M_YIN      = 20'd1 << 8;
   localparam logic [19:0] M_INCPC    = 20'd1 << 9;
   localparam logic [19:0] M_READ     = 20'd1 << 10;
   localparam logic [19:0] M_HIIN     = 20'd1 << 11;
   localparam logic [19:0] M_LOIN     = 20'd1 << 12;
   localparam logic [19:0] M_ZHIGHIN  = 20'd1 << 13;
   localparam logic [19:0] M_ZLOWIN   = 20'd1 << 14;
   localparam logic [19:0] M_GRA      = 20'd1 << 15;
   localparam logic [19:0] M_GRB      = 20'd1 << 16;
   localparam logic [19:0] M_GRC      = 20'd1 << 17;
   localparam logic [19:0] M_RIN      = 20'd1 << 18;
   localparam logic [19:0] M_ROUT     = 20'd1 << 19;

   localparam int C_RTYPE = 0, C_UNARY = 1, C_MULDIV = 2, C_NOP = 3, C_HALT = 4, C_ILL = 5;

   obs_t sb[$];
   obs_t mon_e, mon_a, chk;
   int   total = 0;
   int   bad = 0;
   int   retired_model = 0;
   logic [4:0] legal_ops [14];

   function automatic obs_t sample();
      obs_t o;
      o.str = {bus.Rout, bus.Rin, bus.Grc, bus.Grb, bus.Gra, bus.ZLowIn, bus.ZHighIn,
               bus.LOin, bus.HIin, bus.Read, bus.IncPC, bus.Yin, bus.IRin, bus.MDRin,
               bus.PCin, bus.MARin, bus.MDRout, bus.Zlowout, bus.Zhighout, bus.PCout};
      o.alu = bus.alu_op;
      o.hlt = halted;
      o.ill = illegal;
      return o;
   endfunction

   function automatic obs_t mk(logic [19:0] s, logic [4:0] a = 5'd0, logic h = 1'b0, logic i = 1'b0);
      obs_t o;
      o.str = s;
      o.alu = a;
      o.hlt = h;
      o.ill = i;
      return o;
   endfunction

   function automatic logic rb();
      return 1'($urandom);
   endfunction

   // opcode classes taken straight from the instruction table
   function automatic int cls(logic [4:0] op);
      if (op >= 5'd3 && op <= 5'd11) return C_RTYPE;
      if (op == 5'd17 || op == 5'd18) return C_UNARY;
      if (op == 5'd15 || op == 5'd16) return C_MULDIV;
      if (op == 5'd26) return C_NOP;
      if (op == 5'd27) return C_HALT;
      return C_ILL;
   endfunction

   task automatic check(input string name, input obs_t act, input obs_t exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got str=%h alu=%h halted=%b illegal=%b, want str=%h alu=%h halted=%b illegal=%b",
                  name, act.str, act.alu, act.hlt, act.ill, exp.str, exp.alu, exp.hlt, exp.ill);
      end
   endtask

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   // apply inputs for the current cycle, queue the expected outputs, advance one cycle
   task automatic emit(input logic r, input logic m, input logic [31:0] i, input obs_t e);
      run = r;
      mem_ready = m;
      bus.ir = i;
      sb.push_back(e);
      @(posedge clock);
      #1;
   endtask

   task automatic do_instr(input logic [31:0] irv, input int waits, input logic run_after);
      logic [4:0] op;
      int c;
      op = irv[31:27];
      c = cls(op);
      emit(rb(), rb(), $urandom, mk(M_PCOUT | M_MARIN | M_INCPC));
      for (int w = 0; w <= waits; w++)
         emit(rb(), (w == waits), $urandom, mk(M_READ | M_MDRIN));
      emit(rb(), rb(), $urandom, mk(M_MDROUT | M_IRIN));
      if (c == C_HALT) begin
         emit(rb(), rb(), irv, mk(20'd0));
         retired_model++;
         return;
      end
      if (c == C_NOP || c == C_ILL) begin
         emit(run_after, rb(), irv, mk(20'd0, 5'd0, 1'b0, c == C_ILL));
         retired_model++;
      end else begin
         if (c == C_MULDIV) emit(rb(), rb(), irv, mk(M_GRA | M_ROUT | M_YIN));
         else               emit(rb(), rb(), irv, mk(M_GRB | M_ROUT | M_YIN));
         if (c == C_RTYPE)       emit(rb(), rb(), irv, mk(M_ZHIGHIN | M_ZLOWIN | M_GRC | M_ROUT, op));
         else if (c == C_MULDIV) emit(rb(), rb(), irv, mk(M_ZHIGHIN | M_ZLOWIN | M_GRB | M_ROUT, op));
         else                    emit(rb(), rb(), irv, mk(M_ZHIGHIN | M_ZLOWIN, op));
         if (c == C_MULDIV) begin
            emit(rb(), rb(), irv, mk(M_ZLOWOUT | M_LOIN));
            emit(run_after, rb(), irv, mk(M_ZHIGHOUT | M_HIIN));
         end else begin
            emit(run_after, rb(), irv, mk(M_ZLOWOUT | M_GRA | M_RIN));
         end
         retired_model++;
      end
      if (!run_after) begin
         repeat ($urandom_range(0, 2)) emit(1'b0, rb(), $urandom, mk(20'd0));
         emit(1'b1, rb(), $urandom, mk(20'd0));
      end
   endtask

   always @(negedge clock) begin
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         mon_a = sample();
         check("cycle", mon_a, mon_e);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
      $fatal(1);
   end

   initial begin
      logic [4:0] op;
      legal_ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA,
                    OP_SHL, OP_DIV, OP_MUL, OP_NEG, OP_NOT, OP_NOP};
      bus.ir = 32'd0;
      repeat (3) @(posedge clock);
      #1;
      check("reset_idle", sample(), mk(20'd0));
      run = 1'b1;
      mem_ready = 1'b1;
      bus.ir = 32'hD8000000;
      @(posedge clock);
      #1;
      check("reset_held_run", sample(), mk(20'd0));
`ifdef SEQ_INSTR_COUNT_EN
      check_val("retired_reset", retired, 32'd0);
`endif

      clear = 1'b1;
      emit(1'b1, 1'b1, $urandom, mk(20'd0));
      do_instr(32'h921B8000, 0, 1'b1);
      do_instr(32'h191A0000, 3, 1'b1);
      do_instr(32'h81880000, 0, 1'b1);
      do_instr(32'hD0000000, 0, 1'b0);
      do_instr(32'hF8000000, 0, 1'b1);
      for (int n = 0; n < 50; n++) begin
         if ($urandom_range(0, 4) == 0) begin
            op = 5'($urandom);
            if (op == OP_HALT) op = OP_NOP;
         end else begin
            op = legal_ops[$urandom_range(0, 13)];
         end
         do_instr({op, 27'($urandom)}, $urandom_range(0, 3), rb());
      end
      do_instr(32'hD8000000, 0, 1'b1);
      repeat (20) emit(1'b1, rb(), $urandom, mk(20'd0, 5'd0, 1'b1));
`ifdef SEQ_INSTR_COUNT_EN
      check_val("retired_main", retired, 32'(retired_model));
`endif

      #2;
      clear = 1'b0;
      #1;
      check("halt_async_clear", sample(), mk(20'd0));

      @(posedge clock);
      #1;
      clear = 1'b1;
      emit(1'b1, 1'b1, $urandom, mk(20'd0));
      emit(1'b0, 1'b1, $urandom, mk(M_PCOUT | M_MARIN | M_INCPC));
      emit(1'b0, 1'b1, $urandom, mk(M_READ | M_MDRIN));
      emit(1'b0, 1'b1, $urandom, mk(M_MDROUT | M_IRIN));
      emit(1'b0, 1'b1, 32'h191A0000, mk(M_GRB | M_ROUT | M_YIN));
      #2;
      chk = sample();
      check("t4_before_clear", chk, mk(M_ZHIGHIN | M_ZLOWIN | M_GRC | M_ROUT, OP_ADD));
      clear = 1'b0;
      #1;
      check("t4_async_clear", sample(), mk(20'd0));
`ifdef SEQ_INSTR_COUNT_EN
      check_val("retired_cleared", retired, 32'd0);
`endif

      @(posedge clock);
      #1;
      clear = 1'b1;
      retired_model = 0;
      emit(1'b1, 1'b1, $urandom, mk(20'd0));
      do_instr(32'hD0000000, 1, 1'b1);
      do_instr(32'hD0000000, 0, 1'b1);
      do_instr(32'hD0000000, 2, 1'b0);
`ifdef SEQ_INSTR_COUNT_EN
      check_val("retired_three_nops", retired, 32'(retired_model));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
